// File: rtl/m_unit_pkg.sv
// Shared types for the M-extension sequencer: FSM states, funct3 op codes,
// m_alu mux select encodings and op-classification helpers.
package m_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_ITER,
        S_DIV_FIX,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    // m_alu multiplier operand extension selects
    localparam logic MUX_MULT_UNSIGNED = 1'b0;
    localparam logic MUX_MULT_SIGNED   = 1'b1;

    // m_alu div/rem result selects
    localparam logic MUX_DR_DIV = 1'b0;
    localparam logic MUX_DR_REM = 1'b1;

    function automatic logic is_div(input op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input op_e op);
        return op[2] & op[1];
    endfunction

    // Signed division variants are DIV and REM (funct3 bit 0 clear).
    function automatic logic is_signed(input op_e op);
        return op[2] & ~op[0];
    endfunction

    function automatic logic mult_a_signed(input op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic mult_b_signed(input op_e op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/m_alu.sv
// Datapath for the M-extension unit: multiplier, restoring-division subtractor,
// and the div/rem result mux with its negated copy.
module m_alu
    import m_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                mux_multA_i,
    input  logic                mux_multB_i,
    input  logic                mux_div_rem_i,
    input  logic [XLEN-1:0]     r_i,
    input  logic [2*XLEN-2:0]   d_i,
    input  logic [XLEN-1:0]     z_i,
    output logic [2*XLEN-1:0]   product_o,
    output logic [XLEN-1:0]     sub_result_o,
    output logic                sub_ge_o,
    output logic [XLEN-1:0]     div_rem_o,
    output logic [XLEN-1:0]     div_rem_neg_o
);

    logic [XLEN-1:0]          mult_b;
    logic signed [2*XLEN-1:0] op_a;
    logic signed [2*XLEN-1:0] op_b;
    logic [XLEN:0]            diff;

    // The multiplier operand lives in the top half of D.
    assign mult_b = d_i[2*XLEN-2:XLEN-1];

    always_comb begin
        op_a = (mux_multA_i == MUX_MULT_SIGNED) ? {{XLEN{r_i[XLEN-1]}}, r_i}
                                                : {{XLEN{1'b0}}, r_i};
        op_b = (mux_multB_i == MUX_MULT_SIGNED) ? {{XLEN{mult_b[XLEN-1]}}, mult_b}
                                                : {{XLEN{1'b0}}, mult_b};
    end

    // Both operands are extended to 2*XLEN, so the truncated product is exact.
    assign product_o = op_a * op_b;

    assign diff         = {1'b0, r_i} - {1'b0, d_i[XLEN-1:0]};
    assign sub_result_o = diff[XLEN-1:0];
    assign sub_ge_o     = ~diff[XLEN];

    assign div_rem_o     = (mux_div_rem_i == MUX_DR_REM) ? r_i : z_i;
    assign div_rem_neg_o = -div_rem_o;

endmodule

// File: rtl/m_unit_seq.sv
// M-extension sequencer: accepts one MUL/DIV/REM op, runs it over m_alu, returns one result.
// Optional build macro M_UNIT_DIV_EARLY_EXIT_EN short-cuts divisions with |rs1| < |rs2|.
module m_unit_seq
    import m_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            busy
);

    localparam int          DW        = 2*XLEN-1;
    localparam logic [4:0]  LAST_ITER = 5'(DIV_ITERS - 1);

    state_e            state_q;
    op_e               op_q;
    logic [4:0]        rd_q;
    logic [4:0]        cnt_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic [XLEN-1:0]   r_q, r_d;
    logic [DW-1:0]     d_q, d_d;
    logic [XLEN-1:0]   z_q, z_d;
    logic              out_valid_q;
    logic [XLEN-1:0]   out_result_q;
    logic [4:0]        out_rd_q;

    op_e               op_in;
    logic              accept;
    logic              sgn_in;
    logic              rs1_neg, rs2_neg;
    logic [XLEN-1:0]   abs1, abs2;
    logic              div_zero, div_ovf, div_short;

    logic              mux_multA, mux_multB, mux_div_rem;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   sub_result;
    logic              sub_ge;
    logic [XLEN-1:0]   div_rem, div_rem_neg;
    logic [XLEN-1:0]   mul_res, fix_res;

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;

    assign accept  = in_valid && in_ready && !kill;
    assign op_in   = op_e'(in_funct3);
    assign sgn_in  = is_signed(op_in);
    assign rs1_neg = sgn_in & in_rs1[XLEN-1];
    assign rs2_neg = sgn_in & in_rs2[XLEN-1];
    assign abs1    = rs1_neg ? -in_rs1 : in_rs1;
    assign abs2    = rs2_neg ? -in_rs2 : in_rs2;

    assign div_zero = (in_rs2 == '0);
    assign div_ovf  = sgn_in && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);

`ifdef M_UNIT_DIV_EARLY_EXIT_EN
    // Quotient is zero and remainder is rs1 itself; divide-by-zero is caught first.
    assign div_short = (abs1 < abs2);
`else
    assign div_short = 1'b0;
`endif

    assign mux_multA   = mult_a_signed(op_q) ? MUX_MULT_SIGNED : MUX_MULT_UNSIGNED;
    assign mux_multB   = mult_b_signed(op_q) ? MUX_MULT_SIGNED : MUX_MULT_UNSIGNED;
    assign mux_div_rem = is_rem(op_q) ? MUX_DR_REM : MUX_DR_DIV;

    m_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .mux_multA_i   (mux_multA),
        .mux_multB_i   (mux_multB),
        .mux_div_rem_i (mux_div_rem),
        .r_i           (r_q),
        .d_i           (d_q),
        .z_i           (z_q),
        .product_o     (product),
        .sub_result_o  (sub_result),
        .sub_ge_o      (sub_ge),
        .div_rem_o     (div_rem),
        .div_rem_neg_o (div_rem_neg)
    );

    assign mul_res = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    assign fix_res = (is_rem(op_q) ? neg_rem_q : neg_quo_q) ? div_rem_neg : div_rem;

    // R/D/Z next-state: operand setup on accept, one restoring step per DIV_ITER cycle.
    always_comb begin
        r_d = r_q;
        d_d = d_q;
        z_d = z_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!is_div(op_in)) begin
                        r_d = in_rs1;
                        d_d = {in_rs2, {(XLEN-1){1'b0}}};
                        z_d = '0;
                    end else if (div_zero) begin
                        r_d = in_rs1;
                        d_d = '0;
                        z_d = '1;
                    end else if (div_ovf) begin
                        r_d = '0;
                        d_d = '0;
                        z_d = {1'b1, {(XLEN-1){1'b0}}};
                    end else begin
                        r_d = abs1;
                        d_d = {abs2, {(XLEN-1){1'b0}}};
                        z_d = '0;
                    end
                end
            end
            S_DIV_ITER: begin
                if ((d_q[DW-1:XLEN] == '0) && sub_ge) begin
                    r_d = sub_result;
                    z_d = {z_q[XLEN-2:0], 1'b1};
                end else begin
                    z_d = {z_q[XLEN-2:0], 1'b0};
                end
                d_d = d_q >> 1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            op_q         <= OP_MUL;
            rd_q         <= '0;
            cnt_q        <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            r_q          <= '0;
            d_q          <= '0;
            z_q          <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
        end else begin
            r_q <= r_d;
            d_q <= d_d;
            z_q <= z_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        rd_q  <= in_rd;
                        cnt_q <= '0;
                        // Special cases bypass the sign fix-up: their results are final.
                        neg_quo_q <= (div_zero || div_ovf) ? 1'b0 : (rs1_neg ^ rs2_neg);
                        neg_rem_q <= (div_zero || div_ovf) ? 1'b0 : rs1_neg;
                        if (!is_div(op_in))
                            state_q <= S_MUL;
                        else if (div_zero || div_ovf || div_short)
                            state_q <= S_DIV_FIX;
                        else
                            state_q <= S_DIV_ITER;
                    end
                end
                S_MUL: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else begin
                        out_result_q <= mul_res;
                        out_rd_q     <= rd_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DIV_ITER: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == LAST_ITER)
                            state_q <= S_DIV_FIX;
                    end
                end
                S_DIV_FIX: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else begin
                        out_result_q <= fix_res;
                        out_rd_q     <= rd_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_unit_seq.sv
// Directed and randomized bench for m_unit_seq against an arithmetic reference model.
// Honours M_UNIT_DIV_EARLY_EXIT_EN when computing expected latencies.
module tb_m_unit_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    m_unit_seq dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .kill       (kill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic straight from the RISC-V M rules.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int     ia, ib, q;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = ia / ib;
                return q;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = ia % ib;
                return q;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Edges counted from the accept edge (as 1) through the edge that raises out_valid.
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        longint ma, mb;
        if (!f3[2]) return 2;
        if (b == 0) return 2;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        if (!f3[0]) begin
            ma = $signed(a);
            mb = $signed(b);
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = {32'd0, a};
            mb = {32'd0, b};
        end
`ifdef M_UNIT_DIV_EARLY_EXIT_EN
        if (ma < mb) return 2;
`else
        if (ma < 0 || mb < 0) return 0;
`endif
        return 34;
    endfunction

    // Issue one op from a negedge, check latency/result/tag, hold out_ready low for
    // 'hold' cycles checking stability, then retire it. Ends on a negedge.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold, input string tag);
        int          lat;
        int          guard;
        logic [31:0] exp_r;
        int          exp_l;
        exp_r = ref_result(f3, a, b);
        exp_l = ref_latency(f3, a, b);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_rs1    = a;
        in_rs2    = b;
        in_rd     = rd;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_l));
        check({tag, ".result"}, out_result, exp_r);
        check({tag, ".rd"}, 32'(out_rd), 32'(rd));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_result"}, out_result, exp_r);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".retired"}, 32'(out_valid), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic seen_valid;
        int   guard;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_funct3 = 3'd0;
        in_rs1    = 32'd0;
        in_rs2    = 32'd0;
        in_rd     = 5'd0;
        kill      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_result", out_result, 32'd0);
        check("reset.out_rd", 32'(out_rd), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        resetn = 1'b1;
        @(negedge clk);

        do_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 0, "mulhsu");
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd2, 0, "div_neg7_2");
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, "rem_neg7_2");
        do_op(3'b101, 32'd5, 32'd0, 5'd4, 0, "divu_by0");
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0, "rem_ovf");
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, "div_ovf");

        // Kill a DIVU around its tenth iteration.
        in_valid  = 1'b1;
        in_funct3 = 3'b101;
        in_rs1    = 32'd100;
        in_rs2    = 32'd7;
        in_rd     = 5'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("kill.busy_before", 32'(busy), 32'd1);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill.out_valid", 32'(out_valid), 32'd0);
        check("kill.in_ready", 32'(in_ready), 32'd1);
        check("kill.busy", 32'(busy), 32'd0);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("kill.no_late_valid", 32'(seen_valid), 32'd0);
        do_op(3'b000, 32'd3, 32'd4, 5'd8, 0, "mul_after_kill");

        do_op(3'b111, 32'd3, 32'd10, 5'd9, 5, "remu_hold");

        // Reset in the middle of a division drops it.
        in_valid  = 1'b1;
        in_funct3 = 3'b101;
        in_rs1    = 32'd1000;
        in_rs2    = 32'd3;
        in_rd     = 5'd10;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("midreset.out_valid", 32'(out_valid), 32'd0);
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // kill alongside in_valid in IDLE: not accepted.
        in_valid  = 1'b1;
        kill      = 1'b1;
        in_funct3 = 3'b000;
        in_rs1    = 32'd5;
        in_rs2    = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        kill     = 1'b0;
        check("idle_kill.busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("idle_kill.out_valid", 32'(out_valid), 32'd0);

        // kill in DONE is ignored.
        in_valid  = 1'b1;
        in_funct3 = 3'b011;
        in_rs1    = 32'd7;
        in_rs2    = 32'd6;
        in_rd     = 5'd11;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("done_kill.out_valid", 32'(out_valid), 32'd1);
        check("done_kill.result", out_result, ref_result(3'b011, 32'd7, 32'd6));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  5'($urandom), $urandom_range(0, 2), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
